booth_multiplier_seq: RTL and testbench

- Sequential signed multiplier (radix-2 Booth) in the arithmetic unit.
- Consumes the two's-complement negation of the multiplicand to implement the Booth subtract step, so subtraction reuses the negation path instead of a dedicated subtractor.
- Takes two WIDTH-bit signed operands under a start/done handshake and returns the 2*WIDTH-bit signed product after a fixed WIDTH+1 cycles.

---
 rtl/booth_multiplier_seq_if.sv | 32 +++
 rtl/booth_multiplier_seq.sv | 141 ++++++++++++++
 tb/tb_booth_multiplier_seq.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/booth_multiplier_seq_if.sv
// Start/done handshake bundle for booth_multiplier_seq.
// The abort signal exists only when MUL_ABORT_EN is defined.
interface booth_multiplier_seq_if #(
  parameter int WIDTH = 32
);
  logic                   start;
  logic [WIDTH-1:0]       multiplicand;
  logic [WIDTH-1:0]       multiplier;
  logic                   ready;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     product;
`ifdef MUL_ABORT_EN
  logic                   abort;
`endif

  modport master (
`ifdef MUL_ABORT_EN
    output abort,
`endif
    output start, multiplicand, multiplier,
    input  ready, busy, done, product
  );

  modport slave (
`ifdef MUL_ABORT_EN
    input  abort,
`endif
    input  start, multiplicand, multiplier,
    output ready, busy, done, product
  );
endinterface

// File: rtl/booth_multiplier_seq.sv
// Sequential radix-2 Booth signed multiplier, WIDTH+1 cycles from accepted start to done.
// Optional MUL_ABORT_EN adds an abort input that cancels a running multiply.
module booth_multiplier_seq #(
  parameter int WIDTH = 32
) (
  input logic                   clk,
  input logic                   rst_n,
  booth_multiplier_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_s;
  logic [WIDTH:0]       a_r;
  logic [WIDTH-1:0]     qreg_r;
  logic                 q1_r;
  logic [WIDTH:0]       mx_r;
  logic [WIDTH:0]       negm_r;
  logic [CW-1:0]        count_r;
  logic [2*WIDTH-1:0]   product_r;
  logic                 ready_r;
  logic                 busy_r;
  logic                 done_r;
  logic [WIDTH:0]       sum_s;
  logic [WIDTH:0]       a_step_s;
  logic [WIDTH-1:0]     q_step_s;
  logic                 abort_s;
  logic [WIDTH:0]       mx_load_s;

`ifdef MUL_ABORT_EN
  assign abort_s = bus.abort;
`else
  assign abort_s = 1'b0;
`endif

  // Guard bit keeps the most negative multiplicand exact when negated.
  assign mx_load_s = {bus.multiplicand[WIDTH-1], bus.multiplicand};

  // Booth add/subtract followed by arithmetic right shift of {A,Q,q_1}.
  always_comb begin
    sum_s = a_r;
    case ({qreg_r[0], q1_r})
      2'b01:   sum_s = a_r + mx_r;
      2'b10:   sum_s = a_r + negm_r;
      default: sum_s = a_r;
    endcase
    a_step_s = {sum_s[WIDTH], sum_s[WIDTH:1]};
    q_step_s = {sum_s[0], qreg_r[WIDTH-1:1]};
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort_s) begin
          state_s = ST_IDLE;
        end else if (count_r == CW'(1)) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register and handshake flags, registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      ready_r <= (state_s == ST_IDLE);
      busy_r  <= (state_s == ST_RUN);
      done_r  <= (state_r == ST_DONE);
    end
  end

  // Datapath: operand load, Booth iteration and product capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r       <= {(WIDTH+1){1'b0}};
      qreg_r    <= {WIDTH{1'b0}};
      q1_r      <= 1'b0;
      mx_r      <= {(WIDTH+1){1'b0}};
      negm_r    <= {(WIDTH+1){1'b0}};
      count_r   <= {CW{1'b0}};
      product_r <= {(2*WIDTH){1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            a_r     <= {(WIDTH+1){1'b0}};
            qreg_r  <= bus.multiplier;
            q1_r    <= 1'b0;
            mx_r    <= mx_load_s;
            negm_r  <= ~mx_load_s + {{WIDTH{1'b0}}, 1'b1};
            count_r <= CW'(WIDTH);
          end else begin
            count_r <= count_r;
          end
        end
        ST_RUN: begin
          if (!abort_s) begin
            a_r     <= a_step_s;
            qreg_r  <= q_step_s;
            q1_r    <= qreg_r[0];
            count_r <= count_r - CW'(1);
          end else begin
            count_r <= {CW{1'b0}};
          end
        end
        ST_DONE: product_r <= {a_r[WIDTH-1:0], qreg_r};
        default: count_r <= {CW{1'b0}};
      endcase
    end
  end

  assign bus.ready   = ready_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.product = product_r;
endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Randomized self-checking bench for booth_multiplier_seq against a plain signed-multiply model.
module tb_booth_multiplier_seq;
  localparam int W = 32;
  localparam int LAT = W + 1;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  booth_multiplier_seq_if #(.WIDTH(W)) bus ();

  booth_multiplier_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W-1:0] model_mul(input logic [W-1:0] m, input logic [W-1:0] q);
    logic signed [2*W-1:0] ms;
    logic signed [2*W-1:0] qs;
    ms = $signed({{W{m[W-1]}}, m});
    qs = $signed({{W{q[W-1]}}, q});
    return ms * qs;
  endfunction

  task automatic issue_start(input logic [W-1:0] m, input logic [W-1:0] q);
    @(negedge clk);
    bus.multiplicand = m;
    bus.multiplier   = q;
    bus.start        = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] m, input logic [W-1:0] q,
                        input logic [2*W-1:0] exp);
    int cnt;
    issue_start(m, q);
    cnt = 0;
    while (!bus.done && cnt < 100) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check_val({tag, "_latency"}, 64'(cnt), 64'(LAT));
    check_val({tag, "_product"}, bus.product, exp);
  endtask

  initial begin
    int dones;
    logic [2*W-1:0] seen;
    logic [2*W-1:0] prior;
    logic [W-1:0] rm;
    logic [W-1:0] rq;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.start        = 1'b0;
    bus.multiplicand = {W{1'b0}};
    bus.multiplier   = {W{1'b0}};
`ifdef MUL_ABORT_EN
    bus.abort = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ready", 64'(bus.ready), 64'd1);
    check_val("rst_busy", 64'(bus.busy), 64'd0);
    check_val("rst_done", 64'(bus.done), 64'd0);
    check_val("rst_product", bus.product, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // First op also checks the ready/busy response right after acceptance.
    issue_start(32'd3, 32'd5);
    check_val("ready_fall", 64'(bus.ready), 64'd0);
    check_val("busy_rise", 64'(bus.busy), 64'd1);
    begin
      int cnt;
      cnt = 0;
      while (!bus.done && cnt < 100) begin
        @(posedge clk);
        #1;
        cnt++;
      end
      check_val("m3q5_latency", 64'(cnt), 64'(LAT));
      check_val("m3q5_product", bus.product, 64'h0000_0000_0000_000F);
      check_val("done_ready", 64'(bus.ready), 64'd1);
    end
    @(posedge clk);
    #1;
    check_val("done_pulse_width", 64'(bus.done), 64'd0);

    run_op("neg7x6", 32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6);
    run_op("maxpos", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001);
    run_op("minmin", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    run_op("minx1", 32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000);
    run_op("zero", 32'd0, 32'hDEAD_BEEF, 64'd0);

    // Starts during RUN (cycle 5) and DONE (cycle 33) must be ignored.
    issue_start(32'd2, 32'd2);
    dones = 0;
    seen  = '0;
    for (int c = 1; c <= 80; c++) begin
      if (c == 5 || c == 33) begin
        bus.multiplicand = 32'd9;
        bus.multiplier   = 32'd9;
        bus.start        = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (bus.done) begin
        dones++;
        seen = bus.product;
      end
    end
    bus.start = 1'b0;
    check_val("ignore_done_count", 64'(dones), 64'd1);
    check_val("ignore_product", seen, 64'd4);
    run_op("after_ignore", 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);

    // Asynchronous reset in the middle of a run.
    issue_start(32'd11, 32'd13);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("midrst_ready", 64'(bus.ready), 64'd1);
    check_val("midrst_busy", 64'(bus.busy), 64'd0);
    check_val("midrst_product", bus.product, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    check_val("midrst_no_done", 64'(dones), 64'd0);
    run_op("m4xneg4", 32'd4, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFF0);

`ifdef MUL_ABORT_EN
    prior = bus.product;
    issue_start(32'd5, 32'd5);
    repeat (2) @(posedge clk);
    #1;
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    check_val("abort_ready", 64'(bus.ready), 64'd1);
    check_val("abort_busy", 64'(bus.busy), 64'd0);
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    check_val("abort_no_done", 64'(dones), 64'd0);
    check_val("abort_product_held", bus.product, prior);
    run_op("abort_rerun", 32'd5, 32'd5, 64'd25);
`else
    prior = '0;
`endif

    for (int i = 0; i < 24; i++) begin
      rm = $urandom;
      rq = $urandom;
      if (i % 6 == 1) rm = 32'h8000_0000;
      if (i % 6 == 2) rq = 32'h8000_0000;
      if (i % 6 == 3) rq = 32'hFFFF_FFFF;
      run_op($sformatf("rand%0d", i), rm, rq, model_mul(rm, rq));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
